// File: rtl/dds_cfg_pkg.sv
// Shared definitions for the DDS configuration frame parser: framing constants,
// waveform codes, parser state encoding and the checksum fold helper.
package dds_cfg_pkg;

  localparam logic [7:0] HEADER    = 8'hA5;
  localparam int         FRAME_LEN = 10;

  typedef enum logic [1:0] {
    SINE   = 2'd0,
    TRIANG = 2'd1,
    SQUARE = 2'd2
  } wave_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2
  } parse_state_e;

  // Frame checksum is a plain byte-wise XOR parity.
  function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/dds_config_parser_byte_timeout.sv
// Inter-byte idle counter: counts enabled cycles without a byte and flags the
// cycle in which the silence reaches TIMEOUT_CYC.
module byte_timeout #(
  parameter int TIMEOUT_CYC = 1_250_000
) (
  input  logic sysclk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int             CW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count_r;

  // Idle counter: restarts on every byte, wraps once the timeout has fired.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      count_r <= {CW{1'b0}};
    end else if (clear) begin
      count_r <= {CW{1'b0}};
    end else if (enable) begin
      count_r <= (count_r == LAST) ? {CW{1'b0}} : count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = enable && !clear && (count_r == LAST);

endmodule

// File: rtl/dds_config_parser.sv
// Parses 10-byte UART configuration frames and loads per-channel DDS settings
// (waveform, phase step, offset, amplitude) after checksum and range checks.
module dds_config_parser
  import dds_cfg_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int TIMEOUT_CYC = 1_250_000
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [2*N_CH-1:0]    cfg_type,
  output logic [16*N_CH-1:0]   cfg_M,
  output logic [16*N_CH-1:0]   cfg_offset,
  output logic [16*N_CH-1:0]   cfg_amplitude,
  output logic [N_CH-1:0]      cfg_update,
  output logic                 frame_err,
  output logic [7:0]           err_count
);

  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 2);
  localparam logic [7:0] N_CH_B   = 8'(N_CH);

  parse_state_e state_r, state_s;
  logic [3:0]   idx_r;
  logic [7:0]   xor_r, ch_r, type_r;
  logic [15:0]  m_r, off_r, amp_r;
  logic         expired_s, accept_s, reject_s, frame_ok_s;

  byte_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .sysclk  (sysclk),
    .reset   (reset),
    .clear   (rx_valid),
    .enable  (state_r != IDLE),
    .expired (expired_s)
  );

  assign frame_ok_s = (rx_data == xor_r) && (ch_r < N_CH_B) && (type_r <= {6'd0, SQUARE});

  // Next-state and accept/reject decision.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    reject_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (rx_valid && (rx_data == HEADER)) state_s = COLLECT;
        else                                 state_s = IDLE;
      end
      COLLECT: begin
        if (expired_s) begin
          state_s  = IDLE;
          reject_s = 1'b1;
        end else if (rx_valid && (idx_r == LAST_IDX)) begin
          state_s = CHECK;
        end else begin
          state_s = COLLECT;
        end
      end
      CHECK: begin
        if (expired_s) begin
          state_s  = IDLE;
          reject_s = 1'b1;
        end else if (rx_valid) begin
          state_s  = IDLE;
          accept_s = frame_ok_s;
          reject_s = !frame_ok_s;
        end else begin
          state_s = CHECK;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Parser state register.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Field capture and running checksum while a frame is being collected.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      idx_r  <= 4'd0;
      xor_r  <= 8'd0;
      ch_r   <= 8'd0;
      type_r <= 8'd0;
      m_r    <= 16'd0;
      off_r  <= 16'd0;
      amp_r  <= 16'd0;
    end else if (state_r == IDLE && rx_valid && rx_data == HEADER) begin
      idx_r <= 4'd1;
      xor_r <= 8'd0;
    end else if (state_r == COLLECT && rx_valid) begin
      idx_r <= idx_r + 4'd1;
      xor_r <= chk_fold(xor_r, rx_data);
      case (idx_r)
        4'd1:    ch_r         <= rx_data;
        4'd2:    type_r       <= rx_data;
        4'd3:    m_r[15:8]    <= rx_data;
        4'd4:    m_r[7:0]     <= rx_data;
        4'd5:    off_r[15:8]  <= rx_data;
        4'd6:    off_r[7:0]   <= rx_data;
        4'd7:    amp_r[15:8]  <= rx_data;
        4'd8:    amp_r[7:0]   <= rx_data;
        default: idx_r        <= idx_r + 4'd1;
      endcase
    end else begin
      idx_r <= idx_r;
    end
  end

  // Output registers: only the addressed channel loads on an accepted frame.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      cfg_type      <= {(2*N_CH){1'b0}};
      cfg_M         <= {(16*N_CH){1'b0}};
      cfg_offset    <= {(16*N_CH){1'b0}};
      cfg_amplitude <= {(16*N_CH){1'b0}};
      cfg_update    <= {N_CH{1'b0}};
      frame_err     <= 1'b0;
      err_count     <= 8'd0;
    end else begin
      cfg_update <= {N_CH{1'b0}};
      frame_err  <= reject_s;
      for (int k = 0; k < N_CH; k++) begin
        if (accept_s && (ch_r == 8'(k))) begin
          cfg_type[2*k +: 2]       <= type_r[1:0];
          cfg_M[16*k +: 16]        <= m_r;
          cfg_offset[16*k +: 16]   <= off_r;
          cfg_amplitude[16*k +: 16] <= amp_r;
          cfg_update[k]            <= 1'b1;
        end
      end
      if (reject_s && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
      else                                  err_count <= err_count;
    end
  end

endmodule

// File: tb/tb_dds_config_parser.sv
// Self-checking bench for dds_config_parser: directed scenarios plus random
// frames judged by a frame-level reference model of the acceptance rules.
module tb_dds_config_parser;

  localparam int N_CH = 4;
  localparam int TO   = 50;

  logic                sysclk = 1'b0;
  logic                reset;
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic [2*N_CH-1:0]   cfg_type;
  logic [16*N_CH-1:0]  cfg_M, cfg_offset, cfg_amplitude;
  logic [N_CH-1:0]     cfg_update;
  logic                frame_err;
  logic [7:0]          err_count;

  dds_config_parser #(.N_CH(N_CH), .TIMEOUT_CYC(TO)) dut (
    .sysclk        (sysclk),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .cfg_type      (cfg_type),
    .cfg_M         (cfg_M),
    .cfg_offset    (cfg_offset),
    .cfg_amplitude (cfg_amplitude),
    .cfg_update    (cfg_update),
    .frame_err     (frame_err),
    .err_count     (err_count)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0;
  int errors = 0;

  logic [1:0]  m_type [N_CH];
  logic [15:0] m_M    [N_CH];
  logic [15:0] m_off  [N_CH];
  logic [15:0] m_amp  [N_CH];
  int          m_err;
  logic [7:0]  fr [10];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N_CH; k++) begin
      m_type[k] = 2'd0; m_M[k] = 16'd0; m_off[k] = 16'd0; m_amp[k] = 16'd0;
    end
    m_err = 0;
  endtask

  task automatic check_outputs(input string tag, input logic [N_CH-1:0] eu, input logic ef);
    logic [2*N_CH-1:0]  et;
    logic [16*N_CH-1:0] em, eo, ea;
    for (int k = 0; k < N_CH; k++) begin
      et[2*k +: 2] = m_type[k];
      em[16*k +: 16] = m_M[k];
      eo[16*k +: 16] = m_off[k];
      ea[16*k +: 16] = m_amp[k];
    end
    chk({tag, ".type"}, 64'(cfg_type), 64'(et));
    chk({tag, ".M"}, 64'(cfg_M), 64'(em));
    chk({tag, ".off"}, 64'(cfg_offset), 64'(eo));
    chk({tag, ".amp"}, 64'(cfg_amplitude), 64'(ea));
    chk({tag, ".upd"}, 64'(cfg_update), 64'(eu));
    chk({tag, ".ferr"}, 64'(frame_err), 64'(ef));
    chk({tag, ".cnt"}, 64'(err_count), 64'(m_err));
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge sysclk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic set_frame(input logic [7:0] ch, input logic [7:0] typ, input logic [15:0] m,
                           input logic [15:0] off, input logic [15:0] amp, input bit corrupt);
    logic [7:0] x;
    fr[0] = 8'hA5; fr[1] = ch; fr[2] = typ;
    fr[3] = m[15:8];   fr[4] = m[7:0];
    fr[5] = off[15:8]; fr[6] = off[7:0];
    fr[7] = amp[15:8]; fr[8] = amp[7:0];
    x = 8'd0;
    for (int i = 1; i <= 8; i++) x = x ^ fr[i];
    fr[9] = corrupt ? (x ^ 8'(1 << $urandom_range(0, 7))) : x;
  endtask

  // Frame-level judgement from the acceptance rules; updates model state.
  task automatic model_frame(output logic [N_CH-1:0] eu, output logic ef);
    logic [7:0] x;
    int ch;
    x = 8'd0;
    for (int i = 1; i <= 8; i++) x = x ^ fr[i];
    ch = int'(fr[1]);
    eu = '0;
    if (fr[9] == x && ch < N_CH && fr[2] <= 8'd2) begin
      m_type[ch] = fr[2][1:0];
      m_M[ch]    = {fr[3], fr[4]};
      m_off[ch]  = {fr[5], fr[6]};
      m_amp[ch]  = {fr[7], fr[8]};
      eu[ch]     = 1'b1;
      ef         = 1'b0;
    end else begin
      if (m_err < 255) m_err++;
      ef = 1'b1;
    end
  endtask

  task automatic run_frame(input string tag, input int gap_max);
    logic [N_CH-1:0] eu;
    logic ef;
    for (int i = 0; i < 10; i++) begin
      send_byte(fr[i]);
      if (i < 9 && gap_max > 0) idle($urandom_range(0, gap_max));
    end
    model_frame(eu, ef);
    check_outputs(tag, eu, ef);
  endtask

  initial begin
    rx_data  = 8'd0;
    rx_valid = 1'b0;
    reset    = 1'b0;
    model_reset();
    idle(3);
    check_outputs("reset", '0, 1'b0);
    reset = 1'b1;
    idle(2);

    // Bad checksum on channel-0 frame
    set_frame(8'd0, 8'd0, 16'd100, 16'd0, 16'd500, 1'b0);
    fr[9] = 8'h90;
    run_frame("badchk", 0);
    chk("badchk.cnt1", 64'(err_count), 64'd1);
    chk("badchk.M0", 64'(cfg_M), 64'd0);
    idle(1);
    chk("badchk.pulse_end", 64'(frame_err), 64'd0);

    // Known-good channel-0 frame with CHK 0x91
    set_frame(8'd0, 8'd0, 16'd100, 16'd0, 16'd500, 1'b0);
    chk("good.chk91", 64'(fr[9]), 64'h91);
    run_frame("good", 0);
    chk("good.M", 64'(cfg_M[15:0]), 64'd100);
    chk("good.amp", 64'(cfg_amplitude[15:0]), 64'd500);
    chk("good.upd", 64'(cfg_update), 64'b0001);
    idle(1);
    chk("good.upd_end", 64'(cfg_update), 64'd0);

    // Channel 3 update, then out-of-range channel 4
    set_frame(8'd3, 8'd2, 16'h1234, 16'd2000, 16'h0300, 1'b0);
    run_frame("ch3", 1);
    chk("ch3.M", 64'(cfg_M[63:48]), 64'h1234);
    chk("ch3.off", 64'(cfg_offset[63:48]), 64'd2000);
    chk("ch3.ch0_hold", 64'(cfg_M[15:0]), 64'd100);
    set_frame(8'd4, 8'd1, 16'h5555, 16'h6666, 16'h7777, 1'b0);
    run_frame("ch4", 0);
    chk("ch4.cnt", 64'(err_count), 64'd2);

    // Bad waveform code
    set_frame(8'd1, 8'd3, 16'h0001, 16'h0002, 16'h0003, 1'b0);
    run_frame("type3", 0);

    // Timeout after header plus 3 bytes
    idle(2);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h12);
    for (int i = 0; i < TO; i++) begin
      chk("to.quiet", 64'(frame_err), 64'd0);
      @(negedge sysclk);
    end
    if (m_err < 255) m_err++;
    check_outputs("to.fire", '0, 1'b1);
    idle(1);
    set_frame(8'd2, 8'd1, 16'hBEEF, 16'h0102, 16'h0A0B, 1'b0);
    run_frame("after_to", 0);

    // Noise before a frame
    idle(1);
    send_byte(8'h11); send_byte(8'h22);
    chk("noise.ferr", 64'(frame_err), 64'd0);
    set_frame(8'd1, 8'd0, 16'h0F0F, 16'hF0F0, 16'h1111, 1'b0);
    run_frame("noise", 0);

    // Reset in the middle of a frame
    set_frame(8'd1, 8'd1, 16'h0203, 16'h0405, 16'h0607, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(fr[i]);
    reset = 1'b0;
    idle(2);
    model_reset();
    check_outputs("midrst", '0, 1'b0);
    reset = 1'b1;
    for (int i = 5; i < 10; i++) send_byte(fr[i]);
    check_outputs("midrst.tail", '0, 1'b0);
    idle(TO + 5);
    check_outputs("midrst.quiet", '0, 1'b0);
    set_frame(8'd1, 8'd1, 16'h0203, 16'h0405, 16'h0607, 1'b0);
    run_frame("midrst.next", 0);

    // Random frames, back-to-back and with gaps
    for (int n = 0; n < 150; n++) begin
      int gap;
      set_frame(8'($urandom_range(0, 5)), 8'($urandom_range(0, 3)), 16'($urandom),
                16'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0));
      run_frame("rand", 2);
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        idle(1);
        chk("rand.upd_end", 64'(cfg_update), 64'd0);
        chk("rand.ferr_end", 64'(frame_err), 64'd0);
        idle(gap - 1);
      end
    end

    // Error counter saturation
    for (int n = 0; n < 260; n++) begin
      set_frame(8'($urandom_range(0, 3)), 8'd0, 16'($urandom), 16'($urandom), 16'($urandom), 1'b1);
      run_frame("sat", 0);
    end
    chk("sat.final", 64'(err_count), 64'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
